// File: rtl/ifetch_unit_if.sv
// Fetch-side bundle of the instruction fetch front end: the request/done
// handshake toward the memory controller, the decoder-facing instruction
// queue head, and the global ready / ROB rollback controls.
interface ifetch_unit_if;
  logic        rdy;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic [31:0] iq_pred_pc;
  logic        iq_pop;

  // Fetch unit side
  modport master (
    input  rdy, rollback, rollback_pc, if_done, if_data, iq_pop,
    output if_req_valid, if_req_addr, iq_valid, iq_inst, iq_pc, iq_pred_pc
  );

  // Memory controller / decoder / ROB side
  modport slave (
    output rdy, rollback, rollback_pc, if_done, if_data, iq_pop,
    input  if_req_valid, if_req_addr, iq_valid, iq_inst, iq_pc, iq_pred_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: one outstanding word fetch at a time, static
// JAL redirect at fetch, in-order circular instruction queue toward the
// decoder, and flush/redirect on ROB rollback.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);
  localparam int            AW      = $clog2(QUEUE_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [6:0]    OPC_JAL = 7'b1101111;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   inst_mem [QUEUE_DEPTH];
  logic [31:0]   pc_mem   [QUEUE_DEPTH];
  logic [31:0]   pred_mem [QUEUE_DEPTH];

  logic          push;
  logic          pop;
  logic [31:0]   jal_imm;
  logic [31:0]   next_pc;

  // Static next-PC prediction for the returned word: JAL target or fall-through
  always_comb begin
    jal_imm = {{11{bus.if_data[31]}}, bus.if_data[31], bus.if_data[19:12],
               bus.if_data[20], bus.if_data[30:21], 1'b0};
    if (bus.if_data[6:0] == OPC_JAL) begin
      next_pc = pc_q + jal_imm;
    end else begin
      next_pc = pc_q + 32'd4;
    end
  end

  // Next-state logic: rollback outranks everything, rdy=0 freezes all state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (bus.rdy) begin
      if (bus.rollback) begin
        // Flush the queue and drop any in-flight word; mem_ctrl aborts too
        state_d     = S_IDLE;
        pc_d        = bus.rollback_pc;
        req_valid_d = 1'b0;
        head_d      = '0;
        tail_d      = '0;
        count_d     = '0;
      end else begin
        pop = bus.iq_pop && (count_q != '0);
        case (state_q)
          S_IDLE: begin
            // Issue only with a guaranteed free slot for the returning word
            if (count_q < DEPTH_C) begin
              req_valid_d = 1'b1;
              req_addr_d  = pc_q;
              state_d     = S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.if_done) begin
              req_valid_d = 1'b0;
              push        = 1'b1;
              pc_d        = next_pc;
              state_d     = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase

        if (push) begin
          tail_d = tail_q + AW'(1);
        end
        if (pop) begin
          head_d = head_q + AW'(1);
        end
        if (push && !pop) begin
          count_d = count_q + CW'(1);
        end else if (!push && pop) begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  // Control and pointer registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0000_0000;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Queue storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= bus.if_data;
      pc_mem[tail_q]   <= pc_q;
      pred_mem[tail_q] <= next_pc;
    end
  end

  assign bus.if_req_valid = req_valid_q;
  assign bus.if_req_addr  = req_addr_q;
  assign bus.iq_valid     = (count_q != '0);
  assign bus.iq_inst      = inst_mem[head_q];
  assign bus.iq_pc        = pc_mem[head_q];
  assign bus.iq_pred_pc   = pred_mem[head_q];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a queue-level reference model of the fetch front end
// checked against the DUT every cycle, plus literal expectations for request
// order, JAL redirect, full-queue stall, rollback, rdy freeze and async reset.
module tb_ifetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MEM_LAT  = 3;

  logic clk;
  logic rst;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC   (RESET_PC),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: automatic responder or manually driven done pulses
  logic        mem_auto;
  logic        auto_done;
  logic [31:0] auto_data;
  logic        man_done;
  logic [31:0] man_data;
  int          wait_cnt;

  assign bus.if_done = mem_auto ? auto_done : man_done;
  assign bus.if_data = mem_auto ? auto_data : man_data;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0008: mem_word = 32'h1000_006F;  // jal x0, +0x100
      32'h0000_0110: mem_word = 32'hFF1F_F06F;  // jal x0, -16
      default:       mem_word = 32'h0000_0013;  // nop
    endcase
  endfunction

  // Automatic memory: answers a pending request after MEM_LAT cycles
  initial begin
    auto_done = 1'b0;
    auto_data = 32'h0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (mem_auto && !rst && bus.if_req_valid && !auto_done) begin
        wait_cnt++;
        if (wait_cnt >= MEM_LAT) begin
          auto_done = 1'b1;
          auto_data = mem_word(bus.if_req_addr);
          $display("mem   addr=%08h data=%08h", bus.if_req_addr, auto_data);
        end
      end else begin
        auto_done = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Reference model: queue of fetched entries and one outstanding request
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  ent_t        m_q[$];
  logic        m_pending = 1'b0;
  logic [31:0] m_addr    = 32'h0;
  logic [31:0] m_pc      = RESET_PC;
  ent_t        m_new;
  logic        m_push;
  logic        m_pop;
  int          m_occ;

  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] inst);
    logic signed [20:0] off;
    if (inst[6:0] != 7'h6F) return pc + 32'd4;
    off = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return pc + 32'($signed(off));
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_pending = 1'b0;
        m_addr    = 32'h0;
        m_pc      = RESET_PC;
      end else if (bus.rdy) begin
        if (bus.rollback) begin
          m_q.delete();
          m_pending = 1'b0;
          m_pc      = bus.rollback_pc;
        end else begin
          m_occ  = m_q.size();
          m_pop  = bus.iq_pop && (m_occ > 0);
          m_push = 1'b0;
          if (m_pending) begin
            if (bus.if_done) begin
              m_new.inst = bus.if_data;
              m_new.pc   = m_addr;
              m_new.pred = predict(m_addr, bus.if_data);
              m_push     = 1'b1;
              m_pending  = 1'b0;
              m_pc       = m_new.pred;
              $display("push  pc=%08h inst=%08h pred=%08h", m_new.pc, m_new.inst, m_new.pred);
            end
          end else if (m_occ < DEPTH) begin
            m_pending = 1'b1;
            m_addr    = m_pc;
          end
          if (m_pop) void'(m_q.pop_front());
          if (m_push) m_q.push_back(m_new);
        end
      end
    end
  end

  // Checking
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] req_log[$];
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic compare_all();
    check("req_valid", 32'(bus.if_req_valid), 32'(m_pending));
    if (m_pending) check("req_addr", bus.if_req_addr, m_addr);
    check("iq_valid", 32'(bus.iq_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("iq_inst", bus.iq_inst, m_q[0].inst);
      check("iq_pc", bus.iq_pc, m_q[0].pc);
      check("iq_pred_pc", bus.iq_pred_pc, m_q[0].pred);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
    if (bus.if_req_valid && !prev_valid) req_log.push_back(bus.if_req_addr);
    prev_valid = bus.if_req_valid;
  endtask

  logic [31:0] exp_order [7];
  logic [31:0] jal_pred;
  logic [31:0] got;

  initial begin
    exp_order = '{32'h0, 32'h4, 32'h8, 32'h108, 32'h10C, 32'h110, 32'h100};
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.rollback = 1'b0;
    bus.rollback_pc = 32'h0;
    bus.iq_pop = 1'b1;
    mem_auto = 1'b1;
    man_done = 1'b0;
    man_data = 32'h0;
    jal_pred = 32'hFFFF_FFFF;

    // Reset state
    tick();
    tick();
    check("rst_req_valid", 32'(bus.if_req_valid), 32'h0);
    check("rst_req_addr", bus.if_req_addr, 32'h0);
    check("rst_iq_valid", 32'(bus.iq_valid), 32'h0);

    // Sequential fetch with JAL redirects, decoder always popping
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_req_valid", 32'(bus.if_req_valid), 32'h1);
    check("first_req_addr", bus.if_req_addr, RESET_PC);
    for (int i = 0; i < 300 && req_log.size() < 7; i++) begin
      tick();
      if (bus.iq_valid && bus.iq_pc == 32'h8) jal_pred = bus.iq_pred_pc;
    end
    check("jal_pred_pc", jal_pred, 32'h108);
    for (int i = 0; i < 7; i++) begin
      got = (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF;
      check($sformatf("req_order[%0d]", i), got, exp_order[i]);
    end

    // Rollback to 0x400 and stop popping: exactly four words fill the queue
    @(negedge clk);
    bus.iq_pop = 1'b0;
    bus.rollback = 1'b1;
    bus.rollback_pc = 32'h400;
    tick();
    req_log.delete();
    @(negedge clk);
    bus.rollback = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("full_fetch_count", 32'(req_log.size()), 32'd4);
    check("full_last_req", (req_log.size() == 4) ? req_log[3] : 32'hFFFF_FFFF, 32'h40C);
    check("full_req_valid", 32'(bus.if_req_valid), 32'h0);
    check("full_head_pc", bus.iq_pc, 32'h400);

    // Single pop: request follows one edge later
    @(negedge clk);
    mem_auto = 1'b0;
    bus.iq_pop = 1'b1;
    tick();
    check("pop_edge_req_valid", 32'(bus.if_req_valid), 32'h0);
    check("pop_edge_head_pc", bus.iq_pc, 32'h404);
    @(negedge clk);
    bus.iq_pop = 1'b0;
    tick();
    check("post_pop_req_valid", 32'(bus.if_req_valid), 32'h1);
    check("post_pop_req_addr", bus.if_req_addr, 32'h410);

    // Push and pop in the same cycle: head advances, new word lands at wrapped tail
    @(negedge clk);
    man_done = 1'b1;
    man_data = 32'h0000_0013;
    bus.iq_pop = 1'b1;
    tick();
    check("pushpop_head_pc", bus.iq_pc, 32'h408);
    @(negedge clk);
    man_done = 1'b0;
    tick();
    check("drain_head_pc_1", bus.iq_pc, 32'h40C);
    tick();
    check("drain_head_pc_2", bus.iq_pc, 32'h410);
    check("drain_head_pred", bus.iq_pred_pc, 32'h414);
    tick();
    check("drain_empty", 32'(bus.iq_valid), 32'h0);
    @(negedge clk);
    bus.iq_pop = 1'b0;
    check("pending_addr", bus.if_req_addr, 32'h414);

    // Rollback in WAIT with a coincident done: word dropped, redirect to 0x200
    @(negedge clk);
    bus.rollback = 1'b1;
    bus.rollback_pc = 32'h200;
    man_done = 1'b1;
    man_data = 32'h0000_0013;
    tick();
    check("rb_req_valid", 32'(bus.if_req_valid), 32'h0);
    check("rb_iq_valid", 32'(bus.iq_valid), 32'h0);
    @(negedge clk);
    bus.rollback = 1'b0;
    man_done = 1'b0;
    tick();
    check("rb_next_req_valid", 32'(bus.if_req_valid), 32'h1);
    check("rb_next_req_addr", bus.if_req_addr, 32'h200);

    // rdy low for five cycles with done, pop and rollback activity: nothing moves
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.rdy = 1'b0;
      man_done = 1'b1;
      man_data = 32'hFF1F_F06F;
      bus.iq_pop = (i == 1);
      bus.rollback = (i == 2);
      bus.rollback_pc = 32'h999;
      tick();
    end
    check("frz_req_valid", 32'(bus.if_req_valid), 32'h1);
    check("frz_req_addr", bus.if_req_addr, 32'h200);
    check("frz_iq_valid", 32'(bus.iq_valid), 32'h0);
    @(negedge clk);
    bus.rdy = 1'b1;
    man_done = 1'b0;
    bus.iq_pop = 1'b0;
    bus.rollback = 1'b0;
    tick();
    check("thaw_req_addr", bus.if_req_addr, 32'h200);
    @(negedge clk);
    man_done = 1'b1;
    man_data = 32'h0000_0013;
    tick();
    check("thaw_iq_pc", bus.iq_pc, 32'h200);
    check("thaw_iq_pred", bus.iq_pred_pc, 32'h204);
    @(negedge clk);
    man_done = 1'b0;
    tick();

    // Asynchronous reset mid-transfer, then a stray done while idle
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_valid", 32'(bus.if_req_valid), 32'h0);
    check("arst_iq_valid", 32'(bus.iq_valid), 32'h0);
    check("arst_req_addr", bus.if_req_addr, 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    man_done = 1'b1;
    man_data = 32'h0000_0013;
    tick();
    check("stray_done_req_valid", 32'(bus.if_req_valid), 32'h1);
    check("stray_done_req_addr", bus.if_req_addr, RESET_PC);
    check("stray_done_iq_valid", 32'(bus.iq_valid), 32'h0);
    @(negedge clk);
    man_done = 1'b0;
    mem_auto = 1'b1;
    bus.iq_pop = 1'b1;
    for (int i = 0; i < 25; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
